// File: rtl/regfile_write_arbiter_if.sv
// Writeback bundle between the two writeback sources
// and the single register-file write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  a_valid;
  logic                  a_ready;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  b_valid;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  rf_we, rf_addr, rf_wdata
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output rf_we, rf_addr, rf_wdata
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port
// (A = ALU, B = load) with a sweep-to-zero clear sequencer.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREGS      = 32,
  parameter bit DROP_ZERO  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_write_arbiter_if.slave bus,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NREGS - 1);

  state_t                state_q, state_d;
  // 0: A was granted last, 1: B was granted last
  logic                  rr_last_q, rr_last_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  clr_done_q, clr_done_d;

  logic                  gnt_a;
  logic                  gnt_b;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;

  // Grant decision: only in IDLE with no clear pending;
  // ties go to the requester not granted last.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst && state_q == S_IDLE && !clr_start) begin
      gnt_a = bus.a_valid &
              (!bus.b_valid || rr_last_q);
      gnt_b = bus.b_valid &
              (!bus.a_valid || !rr_last_q);
    end
  end

  assign bus.a_ready = gnt_a;
  assign bus.b_ready = gnt_b;

  // Select the winning requester's address and data.
  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    unique case (1'b1)
      gnt_a: begin
        gnt_addr = bus.a_addr;
        gnt_data = bus.a_data;
      end
      gnt_b: begin
        gnt_addr = bus.b_addr;
        gnt_data = bus.b_data;
      end
      default: ;
    endcase
  end

  // Next state, round-robin pointer, clear counter
  // and next registered write-port values.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    clr_cnt_d  = clr_cnt_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end else if (gnt_a || gnt_b) begin
          rr_last_d  = gnt_b;
          rf_addr_d  = gnt_addr;
          rf_wdata_d = gnt_data;
          rf_we_d    = !(DROP_ZERO &&
                         gnt_addr == '0);
        end
      end
      S_CLEAR: begin
        rf_we_d    = 1'b1;
        rf_addr_d  = clr_cnt_q;
        rf_wdata_d = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_last_q  <= 1'b1;
      clr_cnt_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      clr_cnt_q  <= clr_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign clr_busy     = (state_q == S_CLEAR);
  assign clr_done     = clr_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with a
// behavioural register file on the write port.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic clr_start;
  logic clr_busy;
  logic clr_done;

  logic [31:0] mem [32];
  logic [4:0]  read_sel_1;
  logic [31:0] read_data_1;

  wr_t q[$];
  wr_t exp_w;
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) bus ();

  regfile_write_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NREGS(32),
    .DROP_ZERO(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .clr_start(clr_start),
    .clr_busy(clr_busy),
    .clr_done(clr_done)
  );

  always @(posedge clk)
    if (bus.rf_we === 1'b1)
      mem[bus.rf_addr] <= bus.rf_wdata;

  assign read_data_1 = mem[read_sel_1];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               n, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a,
                      input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    q.push_back(w);
  endtask

  // Monitor: every write on the port must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %0d/%h expected none",
                 bus.rf_addr, bus.rf_wdata);
      end else begin
        exp_w = q.pop_front();
        chk("wr_addr", 32'(bus.rf_addr), 32'(exp_w.a));
        chk("wr_data", bus.rf_wdata, exp_w.d);
      end
    end
  end

  task automatic drive(input logic av,
                       input logic [4:0] aa,
                       input logic [31:0] ad,
                       input logic bv,
                       input logic [4:0] ba,
                       input logic [31:0] bd,
                       input logic ea,
                       input logic eb);
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
    #1;
    chk("a_ready", 32'(bus.a_ready), 32'(ea));
    chk("b_ready", 32'(bus.b_ready), 32'(eb));
    if (ea && aa != 5'd0) push(aa, ad);
    if (eb && ba != 5'd0) push(ba, bd);
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    clr_start   = 1'b0;
    read_sel_1  = '0;
    bus.a_valid = 1'b0;
    bus.a_addr  = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_addr  = '0;
    bus.b_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    chk("rst_a_ready", 32'(bus.a_ready), 0);
    chk("rst_b_ready", 32'(bus.b_ready), 0);
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_rf_addr", 32'(bus.rf_addr), 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    chk("rst_clr_done", 32'(clr_done), 0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // round robin from reset: A, B, A, B
    drive(1, 5'd1, 32'h101, 1, 5'd2, 32'h201, 1, 0);
    drive(1, 5'd1, 32'h102, 1, 5'd2, 32'h202, 0, 1);
    drive(1, 5'd1, 32'h103, 1, 5'd2, 32'h203, 1, 0);
    drive(1, 5'd1, 32'h104, 1, 5'd2, 32'h204, 0, 1);

    // A alone
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0);

    // B to address 0 is accepted but dropped
    drive(0, 5'd0, 32'h0, 1, 5'd0, 32'h7, 0, 1);
    chk("drop_we", 32'(bus.rf_we), 0);
    chk("drop_addr", 32'(bus.rf_addr), 0);
    chk("drop_wdata", bus.rf_wdata, 32'h7);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    chk("idle_we", 32'(bus.rf_we), 0);
    chk("idle_wdata_hold", bus.rf_wdata, 32'h7);

    // full clear with A waiting
    clr_start   = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 5'd9;
    bus.a_data  = 32'h99;
    #1;
    chk("clr_a_block", 32'(bus.a_ready), 0);
    chk("clr_b_block", 32'(bus.b_ready), 0);
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    chk("clr_busy_on", 32'(clr_busy), 1);
    for (int i = 0; i < 32; i++) push(5'(i), 32'h0);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      clr_start = (i == 5);
      chk("clr_done", 32'(clr_done), 32'(i == 31));
      chk("clr_busy", 32'(clr_busy), 32'(i != 31));
      chk("clr_a_ready", 32'(bus.a_ready), 32'(i == 31));
    end
    clr_start = 1'b0;
    push(5'd9, 32'h99);
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

    // reset aborts a clear part way through
    drive(1, 5'd20, 32'h2020, 0, 5'd0, 32'h0, 1, 0);
    drive(1, 5'd10, 32'h1010, 0, 5'd0, 32'h0, 1, 0);
    drive(1, 5'd5, 32'h55, 0, 5'd0, 32'h0, 1, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    clr_start = 1'b1;
    @(posedge clk);
    #1;
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) push(5'(i), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_we", 32'(bus.rf_we), 0);
    chk("abort_busy", 32'(clr_busy), 0);
    chk("abort_addr", 32'(bus.rf_addr), 0);
    for (int i = 0; i < 10; i++) begin
      read_sel_1 = 5'(i);
      #1;
      chk("abort_cleared", read_data_1, 32'h0);
    end
    read_sel_1 = 5'd20;
    #1;
    chk("abort_keep20", read_data_1, 32'h2020);
    read_sel_1 = 5'd10;
    #1;
    chk("abort_keep10", read_data_1, 32'h1010);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 5'd0, 32'h0, 1, 5'd4, 32'h44, 0, 1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    chk("post_abort_we", 32'(bus.rf_we), 0);

    // back-to-back writes to the same register
    drive(1, 5'd3, 32'd11, 0, 5'd0, 32'h0, 1, 0);
    drive(1, 5'd3, 32'd22, 0, 5'd0, 32'h0, 1, 0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    read_sel_1 = 5'd3;
    #1;
    chk("b2b_read", read_data_1, 32'd22);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
